best_arr_unloader: RTL and testbench

Result-readout sequencer for the KD-tree ANN core. Triggered by send_best_arr after fsm_done, it walks the best-index memory in the blocked order the host expects and pushes one DATA_WIDTH index per query into the output FIFO, which drains to the io pins. It replaces the fixed 26x19 / BLOCKING=4 readout with a generic row/column/partition/blocking walk. It also adds a raster mode, a configurable read latency and full FIFO backpressure.

---
 rtl/ann_unload_pkg.sv | 22 ++
 rtl/best_arr_unloader_if.sv | 22 ++
 rtl/unload_skid_fifo.sv | 46 ++++
 rtl/best_arr_unloader.sv | 142 ++++++++++++++
 tb/tb_best_arr_unloader.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ann_unload_pkg.sv
// Shared types and helpers for the best-index readout sequencer.
package ann_unload_pkg;

    typedef enum logic {
        ORDER_BLOCKED = 1'b0,
        ORDER_RASTER  = 1'b1
    } order_mode_e;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t DRAIN = 2'd2;

    // A partition row may not divide evenly into blocks; the trailing block is narrower.
    function automatic int calc_last_block_width(input int pw, input int blocking);
        int nb;
        nb = (pw + blocking - 1) / blocking;
        return pw - (nb - 1) * blocking;
    endfunction

endpackage

// File: rtl/best_arr_unloader_if.sv
// Memory read port plus output FIFO push port of the readout sequencer.
interface best_arr_unloader_if #(
    parameter int DATA_WIDTH = 11,
    parameter int ADDR_WIDTH = 9
);
    logic                  mem_ren;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  out_fifo_wenq;
    logic [DATA_WIDTH-1:0] out_fifo_wdata;
    logic                  out_fifo_wfull_n;

    modport master (
        output mem_ren, mem_raddr, out_fifo_wenq, out_fifo_wdata,
        input  mem_rdata, out_fifo_wfull_n
    );

    modport slave (
        input  mem_ren, mem_raddr, out_fifo_wenq, out_fifo_wdata,
        output mem_rdata, out_fifo_wfull_n
    );
endinterface

// File: rtl/unload_skid_fifo.sv
// Small synchronous FIFO holding returned read data; head is combinational, zero latency.
// Caller guarantees no overflow/underflow; write and read may coincide at any occupancy.
module unload_skid_fifo #(
    parameter int DATA_WIDTH = 11,
    parameter int DEPTH      = 2,
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CNT_W-1:0]      count
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wptr] <= wdata;
                wptr      <= ptr_next(wptr);
            end
            if (rd) rptr <= ptr_next(rptr);
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/best_arr_unloader.sv
// Walks the best-index memory in blocked or raster order and pushes one index per query.
// First push RD_LATENCY+1 cycles after start; reads are credit-limited so FIFO stalls never drop data.
module best_arr_unloader
    import ann_unload_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter int ROW_SIZE   = 26,
    parameter int COL_SIZE   = 19,
    parameter int NUM_PARTS  = 2,
    parameter int BLOCKING   = 4,
    parameter int RD_LATENCY = 1,
    parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
    parameter int ADDR_WIDTH = $clog2(NUM_QUERYS)
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic start,
    input  logic order_mode,
    output logic busy,
    output logic done,
    best_arr_unloader_if.master bus
);
    localparam int PW         = ROW_SIZE / NUM_PARTS;
    localparam int NB         = (PW + BLOCKING - 1) / BLOCKING;
    localparam int LW         = calc_last_block_width(PW, BLOCKING);
    localparam int SKID_DEPTH = RD_LATENCY + 1;
    localparam int CNT_W      = $clog2(SKID_DEPTH + 1);

    generate
        if (ROW_SIZE % NUM_PARTS != 0) begin : g_bad_parts
            $error("ROW_SIZE must be a multiple of NUM_PARTS");
        end
        if (RD_LATENCY < 1) begin : g_bad_latency
            $error("RD_LATENCY must be at least 1");
        end
    endgenerate

    state_t                state;
    order_mode_e           order_q;
    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic [ADDR_WIDTH-1:0] px_cnt;
    logic [ADDR_WIDTH-1:0] x_cnt;
    logic [ADDR_WIDTH-1:0] y_cnt;
    logic [ADDR_WIDTH-1:0] xi_cnt;
    logic [ADDR_WIDTH-1:0] blk_addr;
    logic [ADDR_WIDTH-1:0] blk_w_m1;
    logic [RD_LATENCY-1:0] rd_vld;
    logic [CNT_W-1:0]      skid_cnt;
    logic [DATA_WIDTH-1:0] skid_head;
    logic                  push;
    logic                  last_blk;
    int                    occ;

    // A word popped this cycle frees its slot in time for a read issued now, keeping 1 word/cycle.
    always_comb begin
        push     = (skid_cnt != '0) && bus.out_fifo_wfull_n;
        occ      = int'(skid_cnt) + $countones(rd_vld) - int'(push);
        last_blk = (x_cnt == ADDR_WIDTH'(NB - 1));
        blk_w_m1 = last_blk ? ADDR_WIDTH'(LW - 1) : ADDR_WIDTH'(BLOCKING - 1);
        blk_addr = ADDR_WIDTH'(int'(px_cnt) * PW + int'(y_cnt) * ROW_SIZE
                             + int'(x_cnt) * BLOCKING + int'(xi_cnt));
    end

    assign bus.mem_ren        = (state == RUN) && (occ < SKID_DEPTH);
    assign bus.mem_raddr      = (order_q == ORDER_RASTER) ? rd_cnt : blk_addr;
    assign bus.out_fifo_wenq  = push;
    assign bus.out_fifo_wdata = skid_head;
    assign busy               = (state != IDLE);

    unload_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (SKID_DEPTH)
    ) u_skid (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .wr    (rd_vld[RD_LATENCY-1]),
        .wdata (bus.mem_rdata),
        .rd    (push),
        .head  (skid_head),
        .count (skid_cnt)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            order_q <= ORDER_BLOCKED;
            rd_cnt  <= '0;
            px_cnt  <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
            xi_cnt  <= '0;
            rd_vld  <= '0;
            done    <= 1'b0;
        end else begin
            done   <= 1'b0;
            rd_vld <= (rd_vld << 1) | RD_LATENCY'(bus.mem_ren);
            case (state)
                IDLE: begin
                    if (start) begin
                        order_q <= order_mode_e'(order_mode);
                        rd_cnt  <= '0;
                        px_cnt  <= '0;
                        x_cnt   <= '0;
                        y_cnt   <= '0;
                        xi_cnt  <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (bus.mem_ren) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (xi_cnt == blk_w_m1) begin
                            xi_cnt <= '0;
                            if (y_cnt == ADDR_WIDTH'(COL_SIZE - 1)) begin
                                y_cnt <= '0;
                                if (last_blk) begin
                                    x_cnt  <= '0;
                                    px_cnt <= px_cnt + 1'b1;
                                end else begin
                                    x_cnt <= x_cnt + 1'b1;
                                end
                            end else begin
                                y_cnt <= y_cnt + 1'b1;
                            end
                        end else begin
                            xi_cnt <= xi_cnt + 1'b1;
                        end
                        if (rd_cnt == ADDR_WIDTH'(NUM_QUERYS - 1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leaving on the final pop makes done land on the cycle right after it.
                    if (push && skid_cnt == CNT_W'(1) && rd_vld == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_best_arr_unloader.sv
// Directed-plus-random bench: three unloader configurations against a closed-form address model.
module tb_best_arr_unloader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start0 = 0, start1 = 0, start2 = 0;
    logic order0 = 0, order1 = 0, order2 = 0;
    logic busy0, busy1, busy2, done0, done1, done2;
    logic bp_en = 0;

    best_arr_unloader_if #(.DATA_WIDTH(11), .ADDR_WIDTH(9)) bus0 ();
    best_arr_unloader_if #(.DATA_WIDTH(11), .ADDR_WIDTH(9)) bus1 ();
    best_arr_unloader_if #(.DATA_WIDTH(11), .ADDR_WIDTH(6)) bus2 ();

    best_arr_unloader dut0 (.wb_clk_i(clk), .wb_rst_i(rst), .start(start0), .order_mode(order0),
                            .busy(busy0), .done(done0), .bus(bus0));
    best_arr_unloader #(.RD_LATENCY(3)) dut1 (.wb_clk_i(clk), .wb_rst_i(rst), .start(start1),
                            .order_mode(order1), .busy(busy1), .done(done1), .bus(bus1));
    best_arr_unloader #(.ROW_SIZE(16), .COL_SIZE(4), .NUM_PARTS(1), .BLOCKING(4)) dut2 (
                            .wb_clk_i(clk), .wb_rst_i(rst), .start(start2), .order_mode(order2),
                            .busy(busy2), .done(done2), .bus(bus2));

    // Memory models: data = address, all-ones when no read was issued.
    logic [10:0] d0, d2;
    logic [10:0] d1 [3];
    always @(posedge clk) begin
        d0    <= bus0.mem_ren ? {2'b00, bus0.mem_raddr} : 11'h7FF;
        d2    <= bus2.mem_ren ? {5'b0, bus2.mem_raddr} : 11'h7FF;
        d1[0] <= bus1.mem_ren ? {2'b00, bus1.mem_raddr} : 11'h7FF;
        d1[1] <= d1[0];
        d1[2] <= d1[1];
    end
    assign bus0.mem_rdata = d0;
    assign bus1.mem_rdata = d1[2];
    assign bus2.mem_rdata = d2;
    assign bus0.out_fifo_wfull_n = 1'b1;
    assign bus2.out_fifo_wfull_n = 1'b1;

    logic wfull1 = 1'b1;
    always @(posedge clk) begin
        #1 wfull1 = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    assign bus1.out_fifo_wfull_n = wfull1;

    int q0[$], q1[$], q2[$];
    int done_cnt0 = 0, done_cnt1 = 0, done_cnt2 = 0, busy_cyc0 = 0;
    int iss1 = 0, pushed1 = 0, max_occ1 = 0;
    always @(negedge clk) begin
        if (bus0.out_fifo_wenq) q0.push_back(int'(bus0.out_fifo_wdata));
        if (bus1.out_fifo_wenq) q1.push_back(int'(bus1.out_fifo_wdata));
        if (bus2.out_fifo_wenq) q2.push_back(int'(bus2.out_fifo_wdata));
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
        if (done2) done_cnt2++;
        if (busy0) busy_cyc0++;
        if (bus1.mem_ren) iss1++;
        if (bus1.out_fifo_wenq) pushed1++;
        if (iss1 - pushed1 > max_occ1) max_occ1 = iss1 - pushed1;
    end

    int n_assert = 0, n_fail = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // k-th address of the blocked walk, derived directly from the partition/block/row geometry.
    function automatic int blk_model(int k, int rs, int cs, int np, int bl);
        int pw = rs / np;
        int nb = (pw + bl - 1) / bl;
        int px = k / (pw * cs);
        int r  = k % (pw * cs);
        int x  = r / (bl * cs);
        int r2 = r - x * bl * cs;
        int w  = (x == nb - 1) ? pw - x * bl : bl;
        return px * pw + (r2 / w) * rs + x * bl + (r2 % w);
    endfunction

    task automatic check_pass(input string tag, input int got[$], input int base, input int n,
                              input int rs, input int cs, input int np, input int bl, input bit raster);
        int bad = 0, first = -1, fg = 0, fe = 0;
        for (int k = 0; k < n; k++) begin
            int e = raster ? k : blk_model(k, rs, cs, np, bl);
            int g = (base + k < got.size()) ? got[base + k] : -1;
            if (g != e) begin
                if (first < 0) begin first = k; fg = g; fe = e; end
                bad++;
            end
        end
        n_assert++;
        assert (bad === 0) else begin
            n_fail++;
            $error("FAIL %s: %0d bad words, first at %0d got %0d expected %0d", tag, bad, first, fg, fe);
        end
    endtask

    task automatic pulse(input int which, input bit mode);
        @(posedge clk); #1;
        case (which)
            0: begin start0 = 1; order0 = mode; end
            1: begin start1 = 1; order1 = mode; end
            default: begin start2 = 1; order2 = mode; end
        endcase
        @(posedge clk); #1;
        start0 = 0; start1 = 0; start2 = 0;
    endtask

    task automatic wait_done(input string tag, input int which, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = (which == 0) ? done0 : (which == 1) ? done1 : done2;
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int b, dc, bc, s;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ren", int'(bus0.mem_ren), 0);
        chk("rst_raddr", int'(bus0.mem_raddr), 0);
        chk("rst_wenq", int'(bus0.out_fifo_wenq), 0);
        chk("rst_wdata", int'(bus0.out_fifo_wdata), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        #1 rst = 0;

        // Blocked order, no stalls.
        b = q0.size(); dc = done_cnt0;
        pulse(0, 0);
        wait_done("blk", 0, 2000);
        repeat (5) @(negedge clk);
        chk("blk_count", q0.size() - b, 494);
        chk("blk_done_once", done_cnt0 - dc, 1);
        check_pass("blk_seq", q0, b, 494, 26, 19, 2, 4, 0);
        begin
            int first8[8] = '{0, 1, 2, 3, 26, 27, 28, 29};
            for (int i = 0; i < 8; i++) chk($sformatf("blk_first%0d", i), q0[b + i], first8[i]);
        end
        for (int y = 0; y < 19; y++) chk($sformatf("blk_x3_y%0d", y), q0[b + 228 + y], 12 + 26 * y);
        for (int i = 0; i < 4; i++) chk($sformatf("blk_px1_%0d", i), q0[b + 247 + i], 13 + i);

        // Raster order and busy length.
        b = q0.size(); bc = busy_cyc0;
        pulse(0, 1);
        wait_done("ras", 0, 2000);
        repeat (3) @(negedge clk);
        chk("ras_count", q0.size() - b, 494);
        check_pass("ras_seq", q0, b, 494, 26, 19, 2, 4, 1);
        n_assert++;
        assert (busy_cyc0 - bc >= 495 && busy_cyc0 - bc <= 497) else begin
            n_fail++;
            $error("FAIL ras_busy_len: got %0d expected 496+-1", busy_cyc0 - bc);
        end

        // Random backpressure, RD_LATENCY = 3, both orders.
        bp_en = 1;
        for (int m = 0; m < 2; m++) begin
            b = q1.size(); dc = done_cnt1;
            pulse(1, m[0]);
            wait_done("bp", 1, 6000);
            repeat (3) @(negedge clk);
            chk($sformatf("bp_count_m%0d", m), q1.size() - b, 494);
            chk($sformatf("bp_done_m%0d", m), done_cnt1 - dc, 1);
            check_pass($sformatf("bp_seq_m%0d", m), q1, b, 494, 26, 19, 2, 4, m[0]);
        end
        bp_en = 0;
        n_assert++;
        assert (max_occ1 <= 4) else begin
            n_fail++;
            $error("FAIL bp_occupancy: got %0d expected <= 4", max_occ1);
        end

        // Full blocks: 16x4, one partition.
        b = q2.size();
        pulse(2, 0);
        wait_done("full", 2, 500);
        repeat (3) @(negedge clk);
        chk("full_count", q2.size() - b, 64);
        chk("full_word4", q2[b + 4], 16);
        chk("full_word8", q2[b + 8], 32);
        check_pass("full_seq", q2, b, 64, 16, 4, 1, 4, 0);

        // Reset mid-run after 100 pushes.
        b = q0.size();
        pulse(0, 0);
        for (int i = 0; i < 1000 && q0.size() - b < 100; i++) @(negedge clk);
        chk("rstmid_reached100", int'(q0.size() - b >= 100), 1);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rstmid_ren", int'(bus0.mem_ren), 0);
        chk("rstmid_wenq", int'(bus0.out_fifo_wenq), 0);
        chk("rstmid_busy", int'(busy0), 0);
        chk("rstmid_raddr", int'(bus0.mem_raddr), 0);
        chk("rstmid_wdata", int'(bus0.out_fifo_wdata), 0);
        s = q0.size();
        repeat (20) @(negedge clk);
        chk("rstmid_no_push", q0.size() - s, 0);
        b = q0.size();
        pulse(0, 0);
        wait_done("rstmid_again", 0, 2000);
        repeat (3) @(negedge clk);
        chk("rstmid_again_count", q0.size() - b, 494);
        check_pass("rstmid_again_seq", q0, b, 494, 26, 19, 2, 4, 0);

        // start mid-run is ignored; start on the done cycle launches a second pass.
        b = q0.size(); dc = done_cnt0;
        pulse(0, 0);
        repeat (60) @(posedge clk);
        pulse(0, 1);
        wait_done("restart1", 0, 2000);
        start0 = 1; order0 = 0;
        @(posedge clk); #1 start0 = 0;
        wait_done("restart2", 0, 2000);
        repeat (5) @(negedge clk);
        chk("restart_count", q0.size() - b, 988);
        chk("restart_done", done_cnt0 - dc, 2);
        check_pass("restart_pass1", q0, b, 494, 26, 19, 2, 4, 0);
        check_pass("restart_pass2", q0, b + 494, 494, 26, 19, 2, 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
